// File: rtl/masked_cst_if.sv
// masked_cst_if: handshake bundle for masked_cst_pipe; slave = pipe (in_valid/cst/rnd/out_ready in, in_ready/out_valid/out/sent out), master = its driver
interface masked_cst_if #(
  parameter int d = 2,
  parameter int count = 1
);
  localparam int RW = (d > 1) ? count * (d - 1) : 1;
  logic in_valid;
  logic in_ready;
  logic [count-1:0] cst;
  logic [RW-1:0] rnd;
  logic out_valid;
  logic out_ready;
  logic [count*d-1:0] out;
  logic [15:0] sent;
  modport slave (
    input in_valid, cst, rnd, out_ready,
    output in_ready, out_valid, out, sent
  );
  modport master (
    output in_valid, cst, rnd, out_ready,
    input in_ready, out_valid, out, sent
  );
endinterface

// File: rtl/masked_cst_pipe.sv
// masked_cst_pipe: LAT-stage elastic pipe encoding cst into a d-share Boolean masking (rnd masks when MASKED_CST_RAND_EN defined, else affine share d-1 = cst); ports clk, rst, bus (slave: in_valid/in_ready/cst/rnd -> out_valid/out_ready/out/sent)
module masked_cst_pipe #(
  parameter int d = 2,
  parameter int count = 1,
  parameter int LAT = 1
) (
  input logic clk,
  input logic rst,
  masked_cst_if.slave bus
);
  localparam int W = count * d;
  logic [LAT-1:0] v;
  logic [LAT-1:0][W-1:0] data;
  logic [LAT-1:0][W-1:0] src;
  logic [LAT-1:0] src_v;
  logic [LAT-1:0] free;
  logic [W-1:0] enc;
  logic [15:0] sent_q;
  logic unused_rnd;
  assign unused_rnd = ^bus.rnd;
`ifdef MASKED_CST_RAND_EN
  logic x;
  always_comb begin
    enc = '0;
    x = 1'b0;
    for (int i = 0; i < count; i++) begin
      x = bus.cst[i];
      for (int j = 0; j < d - 1; j++) begin
        enc[i*d+j] = bus.rnd[i*(d-1)+j];
        x = x ^ bus.rnd[i*(d-1)+j];
      end
      enc[i*d+d-1] = x;
    end
  end
`else
  always_comb begin
    enc = '0;
    for (int i = 0; i < count; i++) enc[i*d+d-1] = bus.cst[i];
  end
`endif
  for (genvar k = 0; k < LAT; k++) begin : g_free
    assign free[k] = bus.out_ready | ~&v[LAT-1:k];
  end
  if (LAT > 1) begin : g_src
    assign src = {data[LAT-2:0], enc};
    assign src_v = {v[LAT-2:0], bus.in_valid};
  end else begin : g_src1
    assign src = enc;
    assign src_v = bus.in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      data <= '0;
      sent_q <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) begin
        if (free[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) data[k] <= src[k];
        end
      end
      if (v[LAT-1] && bus.out_ready && sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
    end
  end
  assign bus.in_ready = ~rst & free[0];
  assign bus.out_valid = v[LAT-1];
  assign bus.out = data[LAT-1];
  assign bus.sent = sent_q;
endmodule

// File: tb/tb_masked_cst_pipe.sv
// tb_masked_cst_pipe: directed table plus corner sequences for masked_cst_pipe (d=2/count=4/LAT=2 and d=3/count=4/LAT=1)
module tb_masked_cst_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  masked_cst_if #(.d(2), .count(4)) a ();
  masked_cst_if #(.d(3), .count(4)) b ();
  masked_cst_pipe #(.d(2), .count(4), .LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(a));
  masked_cst_pipe #(.d(3), .count(4), .LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(b));
  int pass_n = 0;
  int total_n = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] enc2(input logic [3:0] c, input logic [3:0] r);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef MASKED_CST_RAND_EN
      o[2*i] = r[i];
      o[2*i+1] = c[i] ^ r[i];
`else
      o[2*i+1] = c[i];
`endif
    end
    return o;
  endfunction
  typedef struct {
    logic [3:0] c;
    logic [3:0] r;
    logic [7:0] er;
    logic [7:0] ed;
  } vec_t;
  vec_t tv[5];
  logic [7:0] q[$];
  logic [7:0] hold;
  logic [3:0] cw;
  logic [3:0] rw;
  logic [3:0] x;
  logic [3:0] prev;
  int exp_sent;
  int nb;
  initial begin
    tv[0] = '{4'b1011, 4'b0110, 8'b10_11_01_10, 8'b10_00_10_10};
    tv[1] = '{4'b0101, 4'b1100, 8'b11_01_00_10, 8'b00_10_00_10};
    tv[2] = '{4'b0000, 4'b1111, 8'hFF, 8'h00};
    tv[3] = '{4'b1111, 4'b0000, 8'hAA, 8'hAA};
    tv[4] = '{4'b1111, 4'b1111, 8'h55, 8'hAA};
    rst = 1'b1;
    a.in_valid = 1'b0; a.cst = '0; a.rnd = '0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.cst = '0; b.rnd = '0; b.out_ready = 1'b1;
    tick;
    tick;
    chk("reset out_valid", a.out_valid, 0);
    chk("reset out", a.out, 0);
    chk("reset sent", a.sent, 0);
    chk("reset in_ready", a.in_ready, 0);
    rst = 1'b0;
    #1 chk("in_ready after reset", a.in_ready, 1);
    exp_sent = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      a.in_valid = 1'b1; a.cst = tv[k].c; a.rnd = tv[k].r;
      #1 chk("vec in_ready", a.in_ready, 1);
      tick;
      a.in_valid = 1'b0;
      #1 chk("vec out_valid at 1", a.out_valid, 0);
      tick;
      chk("vec out_valid at 2", a.out_valid, 1);
`ifdef MASKED_CST_RAND_EN
      chk("vec out", a.out, tv[k].er);
`else
      chk("vec out", a.out, tv[k].ed);
`endif
      tick;
      exp_sent++;
      chk("vec drained", a.out_valid, 0);
      chk("vec sent", a.sent, exp_sent);
    end
    a.out_ready = 1'b0;
    a.in_valid = 1'b1; a.cst = 4'h3; a.rnd = 4'h5;
    #1 chk("bp accept 1", a.in_ready, 1);
    tick;
    a.cst = 4'hC; a.rnd = 4'hA;
    #1 chk("bp accept 2", a.in_ready, 1);
    tick;
    a.cst = 4'h9; a.rnd = 4'h6;
    #1 chk("bp in_ready low", a.in_ready, 0);
    hold = a.out;
    chk("bp first word", hold, enc2(4'h3, 4'h5));
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp stall in_ready", a.in_ready, 0);
      chk("bp stall valid", a.out_valid, 1);
      chk("bp stall out", a.out, hold);
    end
    a.out_ready = 1'b1;
    #1 chk("bp full accept", a.in_ready, 1);
    tick;
    a.in_valid = 1'b0;
    chk("bp word 2", a.out, enc2(4'hC, 4'hA));
    chk("bp occupancy", a.out_valid, 1);
    tick;
    chk("bp word 3", a.out, enc2(4'h9, 4'h6));
    tick;
    exp_sent += 3;
    chk("bp empty", a.out_valid, 0);
    chk("bp sent", a.sent, exp_sent);
    for (int c = 0; c < 12; c++) begin
      cw = 4'(c) ^ 4'h5;
      rw = 4'(c * 3);
      a.in_valid = (c < 10);
      a.cst = cw; a.rnd = rw;
      if (c < 10) q.push_back(enc2(cw, rw));
      #1;
      if (c < 10) chk("stream in_ready", a.in_ready, 1);
      if (c >= 2) begin
        chk("stream no bubble", a.out_valid, 1);
        chk("stream out", a.out, q.pop_front());
      end
      tick;
    end
    exp_sent += 10;
    chk("stream drained", a.out_valid, 0);
    chk("stream sent", a.sent, exp_sent);
    a.out_ready = 1'b0;
    a.in_valid = 1'b1; a.cst = 4'h7; a.rnd = 4'h1;
    tick;
    a.cst = 4'hE;
    tick;
    a.in_valid = 1'b0;
    chk("rst in flight", a.out_valid, 1);
    rst = 1'b1;
    tick;
    chk("rst out_valid", a.out_valid, 0);
    chk("rst sent", a.sent, 0);
    chk("rst out", a.out, 0);
    rst = 1'b0;
    a.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rst no stale", a.out_valid, 0);
    end
    chk("rst sent stays 0", a.sent, 0);
    nb = 0;
    prev = '0;
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    while (nb < 65540) begin
      b.cst = 4'($urandom);
      b.rnd = 8'($urandom);
      #1;
      if (b.out_valid) begin
        if (nb < 1000) begin
          for (int i = 0; i < 4; i++) x[i] = ^b.out[i*3 +: 3];
          chk("d3 share xor", x, prev);
        end
        nb++;
      end
      prev = b.cst;
      tick;
      if (nb == 1000 || nb == 65534 || nb == 65535 || nb == 65540)
        chk("d3 sent", b.sent, (nb > 65535) ? 64'hFFFF : 64'(nb));
    end
    b.in_valid = 1'b0;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
